fir_output_stage: RTL and testbench

// - Downstream neighbour of the FIR tap chain. Captures the full-precision y_out of the

---
 rtl/fir_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/fir_output_stage.sv | 106 ++++++++++
 tb/tb_fir_output_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared widths, sample types and the saturation helper
// for the FIR output stage.
package fir_pkg;

  localparam int DEF_ACC_W      = 16;
  localparam int DEF_OUT_W      = 16;
  localparam int DEF_FRAC_SHIFT = 0;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_CNT_W      = 16;

  typedef logic signed [DEF_ACC_W-1:0] acc_t;
  typedef logic signed [DEF_OUT_W-1:0] out_t;

  // Clamp v into the signed range of a w-bit value.
  function automatic logic signed [63:0] sat_clamp(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO: storage, wrapping pointers and
// an explicit occupancy count.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wr_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_output_stage.sv
// FIR output stage: round/shift, saturate, buffer and
// report saturation statistics with valid/ready flow.
module fir_output_stage
  import fir_pkg::*;
#(
  parameter int ACC_W      = DEF_ACC_W,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [ACC_W-1:0] y_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    clr_stat,
  output logic                    ovf_flag,
  output logic [CNT_W-1:0]        sat_count
);

  localparam int RW = ACC_W + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic signed [RW-1:0] RND =
    RW'((2 ** FRAC_SHIFT) / 2);

  logic                 accept;
  logic signed [RW-1:0] rnd_sum;
  logic signed [RW-1:0] s1_data;
  logic                 s1_valid;
  logic signed [63:0]   s1_wide;
  logic signed [63:0]   clamped;
  logic                 sat_hit;
  logic [OUT_W-1:0]     head;
  logic [OUT_W-1:0]     hold;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [AW:0]          count;
  logic [AW+1:0]        occ;

  assign accept  = in_valid & in_ready;
  assign rnd_sum = RW'(y_in) + RND;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_data <= rnd_sum >>> FRAC_SHIFT;
    end
  end

  assign s1_wide = 64'(s1_data);
  assign clamped = sat_clamp(s1_wide, OUT_W);
  assign sat_hit = s1_valid && (clamped != s1_wide);

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (OUT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (s1_valid),
    .wr_data (clamped[OUT_W-1:0]),
    .pop     (pop),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign out_data  = empty ? hold : head;

  // Reserve a slot for the sample already in stage 1.
  assign occ      = {1'b0, count} + (AW+2)'(s1_valid);
  assign in_ready = !full && (occ < (AW+2)'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold <= '0;
    end else if (pop) begin
      hold <= head;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_flag  <= 1'b0;
      sat_count <= '0;
    end else if (clr_stat) begin
      ovf_flag  <= 1'b0;
      sat_count <= '0;
    end else if (sat_hit) begin
      ovf_flag <= 1'b1;
      if (sat_count != '1) sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_output_stage.sv
// Directed and scoreboarded checks of fir_output_stage
// with OUT_W=8, FRAC_SHIFT=4, FIFO_DEPTH=4.
module tb_fir_output_stage;

  logic        clk;
  logic        rst;
  logic [15:0] y_in;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        clr_stat;
  logic        ovf_flag;
  logic [15:0] sat_count;

  int n_chk;
  int n_pass;
  int n_acc;
  int msat;
  int mon_e;
  bit mon_s;
  bit mon_en;
  int exp_q[$];

  fir_output_stage #(
    .ACC_W      (16),
    .OUT_W      (8),
    .FRAC_SHIFT (4),
    .FIFO_DEPTH (4),
    .CNT_W      (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .y_in      (y_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .clr_stat  (clr_stat),
    .ovf_flag  (ovf_flag),
    .sat_count (sat_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  tag, got, exp);
  endtask

  function automatic int model(input logic [15:0] y,
                               output bit sat);
    int r;
    r = int'($signed(y)) + 8;
    r = r >>> 4;
    sat = 1'b0;
    if (r > 127) begin
      r = 127;
      sat = 1'b1;
    end else if (r < -128) begin
      r = -128;
      sat = 1'b1;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
  endtask

  // Called just after a rising edge; checks 2-cycle latency.
  task automatic send_one(input logic [15:0] y,
                          input int exp, input string tag);
    y_in = y;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_rdy"}, in_ready, 1);
    chk({tag, "_t0"}, out_valid, 0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_t1"}, out_valid, 0);
    tick();
    @(negedge clk);
    chk({tag, "_t2v"}, out_valid, 1);
    chk({tag, "_t2d"}, $signed(out_data), exp);
    tick();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        chk("mon_q", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          chk("mon_data", $signed(out_data), exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        mon_e = model(y_in, mon_s);
        exp_q.push_back(mon_e);
        if (mon_s) msat++;
        n_acc++;
      end
    end
  end

  initial begin
    int k;
    int acc;
    int got;
    int cyc;
    n_chk = 0;
    n_pass = 0;
    n_acc = 0;
    msat = 0;
    mon_en = 1'b0;
    rst = 1'b0;
    y_in = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    clr_stat = 1'b0;

    #3;
    chk("rst_vld", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovf", ovf_flag, 0);
    chk("rst_sat", sat_count, 0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rdy", in_ready, 1);
    tick();

    send_one(16'h0018, 2, "rnd24");
    send_one(16'h0017, 1, "rnd23");
    send_one(16'hFFE8, -1, "rndm24");
    chk("rnd_ovf", ovf_flag, 0);
    chk("rnd_sat", sat_count, 0);

    send_one(16'h7FFF, 127, "satp");
    send_one(16'h8000, -128, "satn");
    chk("sat_ovf", ovf_flag, 1);
    chk("sat_cnt", sat_count, 2);
    pulse_clr();
    @(negedge clk);
    chk("clr_ovf", ovf_flag, 0);
    chk("clr_sat", sat_count, 0);
    tick();

    out_ready = 1'b0;
    k = 1;
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      y_in = 16'(k * 16);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        acc++;
        k++;
      end
      if (i == 15) chk("bp_rdy", in_ready, 0);
      tick();
    end
    chk("bp_acc", acc, 4);
    in_valid = 1'b0;
    out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) begin
        chk("bp_ord", $signed(out_data), got + 1);
        got++;
      end
      tick();
    end
    chk("bp_cnt", got, 4);

    pulse_clr();
    msat = 0;
    exp_q.delete();
    mon_en = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      y_in = 16'(i * 1311 + 3);
      in_valid = 1'b1;
      @(negedge clk);
      chk("ft_rdy", in_ready, 1);
      if (i >= 2) chk("ft_vld", out_valid, 1);
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    chk("ft_drain", exp_q.size(), 0);
    chk("ft_sat", sat_count, msat);

    mon_en = 1'b0;
    pulse_clr();
    msat = 0;
    n_acc = 0;
    exp_q.delete();
    mon_en = 1'b1;
    cyc = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      in_valid = 1'($urandom);
      out_ready = 1'($urandom);
      y_in = 16'($urandom);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    chk("rnd_bound", int'(n_acc >= 10000), 1);
    chk("rnd_drain", exp_q.size(), 0);
    chk("rnd_sat", sat_count, msat);
    chk("rnd_ovf", ovf_flag, int'(msat > 0));
    mon_en = 1'b0;

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      y_in = 16'h7FFF;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("rm_pre_vld", out_valid, 1);
    chk("rm_pre_sat", int'(sat_count != 0), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rm_vld", out_valid, 0);
    chk("rm_sat", sat_count, 0);
    chk("rm_ovf", ovf_flag, 0);
    chk("rm_data", out_data, 0);
    tick();
    rst = 1'b1;
    tick();
    send_one(16'h0018, 2, "rm_lat");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
